// File: rtl/ser8_tx.sv
// ---------------------------------------------------------------------------
// ser8_tx -- parallel-to-serial byte transmitter
//
// Accepts WIDTH-bit words over a valid/ready handshake and shifts each one out
// one bit per clock. Each frame is exactly WIDTH cycles long and has a
// frame-valid marker and a last-bit marker. A one-word holding buffer lets
// back-to-back words leave as gapless frames.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  0: bit 0 leaves first, 1: bit WIDTH-1 leaves first
//   IDLE_LEVEL level driven on sout while no frame is active
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   din        parallel word to transmit
//   din_valid  din holds a word to send
//   din_ready  a word can be accepted this cycle (holding buffer empty)
//   sout       serial data bit (registered)
//   sout_valid sout carries a frame bit (registered)
//   sout_last  current bit is the final bit of its frame (registered)
//   busy       frame in flight or holding buffer occupied
// ---------------------------------------------------------------------------
module ser8_tx #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shifter_q, shifter_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             sout_last_q, sout_last_d;

    logic             xfer;
    logic             shifter_free;

    // State register; reset discards both the frame in flight and the held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shifter_q    <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            sout_q       <= IDLE_LEVEL;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shifter_q    <= shifter_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sout_last_q  <= sout_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shifter_d   = shifter_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        xfer = din_valid && !hold_full_q;
        // The shifter can take a new word when nothing is in flight or when
        // the final bit of the current frame is on sout right now.
        shifter_free = (state_q == IDLE) || (cnt_q == CNT_LAST);

        if (shifter_free) begin
            if (hold_full_q) begin
                // The held word goes first. A word arriving on the same edge
                // would refill hold; din_ready is low while hold is full, so
                // in practice hold simply empties here.
                shifter_d   = hold_q;
                state_d     = SHIFT;
                cnt_d       = '0;
                hold_full_d = 1'b0;
                if (xfer) begin
                    hold_d      = din;
                    hold_full_d = 1'b1;
                end
            end else if (xfer) begin
                // Hold is empty, so the word bypasses it and goes out directly.
                shifter_d = din;
                state_d   = SHIFT;
                cnt_d     = '0;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else begin
            cnt_d     = cnt_q + CW'(1);
            shifter_d = MSB_FIRST ? (shifter_q << 1) : (shifter_q >> 1);
            if (xfer) begin
                hold_d      = din;
                hold_full_d = 1'b1;
            end
        end

        // Output flops are loaded from next-state values, so they line up
        // with the shifter contents they describe.
        sout_valid_d = (state_d == SHIFT);
        sout_last_d  = (state_d == SHIFT) && (cnt_d == CNT_LAST);
        if (state_d == SHIFT) begin
            sout_d = MSB_FIRST ? shifter_d[WIDTH-1] : shifter_d[0];
        end else begin
            sout_d = IDLE_LEVEL;
        end
    end

    assign din_ready  = !hold_full_q;
    assign busy       = (state_q == SHIFT) || hold_full_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sout_last  = sout_last_q;

endmodule
